// File: rtl/param_sram_ctrl.sv
// Single-port synchronous RAM with registered read, valid strobe and zero-fill clear engine.
// Optional per-word parity storage and checking is enabled by defining PARITY_EN.
`timescale 1ns/1ps

// state    | meaning
// ST_CLEAR | clear engine zero-filling the array, user accesses dropped
// ST_IDLE  | array available for user reads and writes
module param_sram_ctrl #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    input  logic              rden,
    input  logic              clear_req,
    input  logic              err_inject,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic              busy,
    output logic              clear_done,
    output logic              parity_err
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] clr_addr_nxt;
    logic              clr_last;

    logic [WORD_W-1:0] mem [DEPTH];

    logic              user_ok;
    logic              acc_wr;
    logic              acc_rd;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;

    assign busy     = (state == ST_CLEAR);
    assign clr_last = (clr_addr == {ADDR_W{1'b1}});

    // A pending clear request wins over any access presented in the same cycle.
    assign user_ok = (state == ST_IDLE) && !clear_req;
    assign acc_wr  = user_ok && wren;
    assign acc_rd  = user_ok && rden;

`ifdef PARITY_EN
    assign wr_word = {(^data) ^ err_inject, data};
`else
    logic unused_err_inject;
    assign unused_err_inject = err_inject;
    assign wr_word = data;
`endif

    // Write-first: a simultaneous write is forwarded to the read port.
    assign rd_word = acc_wr ? wr_word : mem[address];

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = address;
        mem_wdata = wr_word;
        if (state == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = clr_addr;
            mem_wdata = '0;
        end else if (acc_wr) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        case (state)
            ST_CLEAR: begin
                clr_addr_nxt = clr_addr + ADDR_W'(1);
                if (clr_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                if (clear_req) begin
                    state_nxt    = ST_CLEAR;
                    clr_addr_nxt = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_CLEAR;
            clr_addr   <= '0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            clr_addr   <= clr_addr_nxt;
            clear_done <= (state == ST_CLEAR) && clr_last;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= acc_rd;
            if (acc_rd) begin
                q <= rd_word[DATA_W-1:0];
            end
        end
    end

`ifdef PARITY_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= acc_rd && ((^rd_word[DATA_W-1:0]) != rd_word[DATA_W]);
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_param_sram_ctrl.sv
// Scoreboard bench for param_sram_ctrl: directed scenarios plus random traffic checked
// against an array-based reference model; define PARITY_EN to exercise parity.
`timescale 1ns/1ps

module tb_param_sram_ctrl;

    localparam int DW    = 4;
    localparam int AW    = 5;
    localparam int DEPTH = 2 ** AW;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data = '0;
    logic          wren = 1'b0;
    logic          rden = 1'b0;
    logic          clear_req = 1'b0;
    logic          err_inject = 1'b0;
    logic [DW-1:0] q;
    logic          q_valid;
    logic          busy;
    logic          clear_done;
    logic          parity_err;

    param_sram_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clock(clock), .resetn(resetn), .address(address), .data(data),
        .wren(wren), .rden(rden), .clear_req(clear_req), .err_inject(err_inject),
        .q(q), .q_valid(q_valid), .busy(busy), .clear_done(clear_done),
        .parity_err(parity_err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: word array, stored parity bits, remaining clear cycles.
    logic [DW-1:0] m_mem [DEPTH];
    logic          m_par [DEPTH];
    int            m_left = DEPTH;
    logic          m_done = 1'b0;
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_q = '0;
    logic          m_perr = 1'b0;
    logic [DW:0]   sb [$];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic          rd_perr;
        logic [DW-1:0] rd_q;
        m_valid = 1'b0;
        m_perr  = 1'b0;
        if (m_left > 0) begin
            m_left--;
            m_done = (m_left == 0);
        end else begin
            m_done = 1'b0;
            if (clear_req) begin
                m_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) begin
                    m_mem[i] = '0;
                    m_par[i] = 1'b0;
                end
            end else begin
                if (wren) begin
                    m_mem[address] = data;
                    m_par[address] = (^data) ^ err_inject;
                end
                if (rden) begin
                    rd_q = m_mem[address];
`ifdef PARITY_EN
                    rd_perr = ((^rd_q) != m_par[address]);
`else
                    rd_perr = 1'b0;
`endif
                    m_q     = rd_q;
                    m_perr  = rd_perr;
                    m_valid = 1'b1;
                    sb.push_back({rd_perr, rd_q});
                end
            end
        end
    endtask

    task automatic cyc(input logic w, input logic r, input logic c,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic inj);
        wren = w; rden = r; clear_req = c; address = a; data = d; err_inject = inj;
        @(posedge clock);
        if (resetn) model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic apply_reset();
        #1;
        resetn = 1'b0;
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_q", q, 0);
        chk("rst_q_valid", q_valid, 0);
        m_left = DEPTH; m_done = 1'b0; m_valid = 1'b0; m_q = '0; m_perr = 1'b0;
        sb.delete();
        idle(2);
        resetn = 1'b1;
    endtask

    always @(negedge clock) begin
        logic [DW:0] e;
        chk("busy", busy, int'(m_left > 0));
        chk("clear_done", clear_done, m_done);
        chk("q_valid", q_valid, m_valid);
        chk("q_hold", q, m_q);
        chk("parity_err", parity_err, m_perr);
        if (q_valid) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_q", q, e[DW-1:0]);
                chk("sb_perr", parity_err, e[DW]);
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_par[i] = 1'b0;
        end
        // Power-up clear and read-back of the whole array.
        idle(3);
        resetn = 1'b1;
        idle(DEPTH + 2);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 1'b0, AW'(i), '0, 1'b0);
        idle(2);

        cyc(1'b1, 1'b0, 1'b0, 5'h13, 4'hA, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 5'h13, 4'h0, 1'b0);
        idle(3);

        cyc(1'b1, 1'b1, 1'b0, 5'h07, 4'h5, 1'b0);
        idle(2);

        // Fill, then clear with a simultaneous write that must be dropped.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, AW'(i), DW'(i % 16), 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 5'h02, 4'hF, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                AW'($urandom_range(0, DEPTH - 1)), DW'($urandom_range(0, 15)), 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 1'b0, AW'(i), '0, 1'b0);

        // Reset in the middle of a clear.
        cyc(1'b0, 1'b1, 1'b1, 5'h01, 4'h0, 1'b0);
        idle(10);
        apply_reset();
        idle(DEPTH + 2);

        // Parity: corrupted and clean word with the same data.
        cyc(1'b1, 1'b0, 1'b0, 5'h04, 4'h3, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 5'h05, 4'h3, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 5'h04, 4'h0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 5'h05, 4'h0, 1'b0);
        idle(2);

        for (int i = 0; i < 600; i++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 59) == 0), AW'($urandom_range(0, DEPTH - 1)),
                DW'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0));
        idle(DEPTH + 3);

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/param_sram_ctrl.md
Name: param_sram_ctrl

Overview:
- Parametrised single-port synchronous RAM with registered read, valid strobe and a built-in clear engine.
- Successor to the fixed 32x4 RAM used on the switch/hex lab board. Width and depth are generic.
- After every reset, and on request, the engine zero-fills the whole array. Accesses are locked out while it runs.
- Sits between board I/O (switches/keys, hex display) or a future note-storage controller and the memory array.

Parameters:
- DATA_W, 4, data word width in bits (>=1)
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W words

Ports:
- clock  in  1  single clock; all state changes on the rising edge
- resetn  in  1  asynchronous, active-low reset
- address  in  ADDR_W  user word address
- data  in  DATA_W  user write data
- wren  in  1  write enable, sampled at the clock edge
- rden  in  1  read enable, sampled at the clock edge
- clear_req  in  1  request a full zero-fill
- err_inject  in  1  corrupt the stored parity on this write (used only with PARITY_EN)
- q  out  DATA_W  registered read data
- q_valid  out  1  one-cycle strobe: q updated by an accepted read
- busy  out  1  clear engine running; user accesses dropped
- clear_done  out  1  one-cycle pulse when a clear completes
- parity_err  out  1  parity mismatch on the read currently presented, aligned with q_valid

Behaviour:
- Reset value of every output: q=0, q_valid=0, clear_done=0, parity_err=0, busy=1. Reset also sets state=CLEAR and clr_addr=0.
- Memory contents are not reset asynchronously; the clear engine initialises them.
- Reset asserted mid-clear or mid-access: the operation is aborted immediately. The clear restarts from address 0 after release.
- States: CLEAR and IDLE.
- CLEAR, every edge:
  - writes 0 to mem[clr_addr], then clr_addr += 1.
  - At clr_addr == DEPTH-1, the write happens and state moves to IDLE.
  - A clear takes exactly DEPTH cycles.
- busy = (state == CLEAR), driven combinationally from the state register.
- clear_done is 1 during the first IDLE cycle after a clear, and only then.
- In CLEAR:
  - wren, rden and clear_req are ignored; nothing is queued.
  - q holds its value; q_valid = 0.
- IDLE, accesses:
  - wren=1: mem[address] <= data at the edge.
  - rden=1: q <= mem[address] at the edge, q_valid=1 in the following cycle.
  - Read latency is 1 clock.
  - wren=1 and rden=1 together: write-first. q returns the newly written data and q_valid=1.
  - No read accepted: q holds its last value and q_valid=0.
- IDLE, clear_req=1:
  - The next state is CLEAR with clr_addr=0.
  - clear_req has priority over a simultaneous wren/rden; that user access is dropped, with no write and no q_valid.
  - clear_req=1 during clear_done still starts a new clear.
- Addressing: all 2**ADDR_W addresses are valid. The clr_addr counter is ADDR_W bits and wraps to 0 when the clear ends.
- Back-to-back reads on consecutive cycles give q_valid=1 continuously, with one new word per cycle.

Optional Feature:
- Macro: PARITY_EN.
- When defined:
  - Each word stores one extra bit, p = ^data. If err_inject=1 on a write, ~(^data) is stored instead.
  - The clear engine writes p=0.
  - On each accepted read, parity_err is registered as (^q_word != p) and is valid only while q_valid=1; otherwise it is 0.
- When undefined:
  - No parity storage.
  - parity_err is tied to 0 and err_inject is ignored.
  - Port list is unchanged.

Test Plan (DATA_W=4, ADDR_W=5):
1. Release resetn -> busy=1 for 32 cycles, then clear_done pulses for 1 cycle; reading addresses 0..31 returns q=0 with q_valid=1, one cycle after each rden.
2. Write 0xA to address 0x13, then rden at 0x13 -> q=0xA, q_valid=1 exactly 1 cycle later; q holds 0xA while rden=0 and q_valid=0.
3. wren=1 and rden=1 together, address 0x07, data 0x5 -> next cycle q=0x5, q_valid=1.
4. After filling 0x00..0x1F with address[3:0], pulse clear_req together with wren (addr 0x02, data 0xF) -> write dropped; busy for 32 cycles; wren/rden during busy have no effect; afterwards all reads return 0.
5. Assert resetn=0 at clr_addr=10 of a clear -> busy=1, q=0 and q_valid=0 immediately; after release, the clear runs the full 32 cycles from address 0.
6. PARITY_EN: write 0x3 with err_inject=1 to 0x04 and 0x3 normally to 0x05 -> read 0x04 gives parity_err=1; read 0x05 gives parity_err=0. Without the macro, parity_err stays 0.
